// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS control unit.
// Contents: FSM state encoding, opcode/funct values of the supported
// instructions, ALU control codes, ALU operation classes, and the select
// encodings for the ALU B-operand and PC-source multiplexers.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    RTYPEEX  = 4'd6,
    RTYPEWB  = 4'd7,
    BEQEX    = 4'd8,
    ADDIEX   = 4'd9,
    ADDIWB   = 4'd10,
    JEX      = 4'd11
  } state_t;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU control codes driven to the datapath
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALU operation class handed from the FSM to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU B-operand select
  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALURES = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // True for the R-type functions this control unit can execute.
  function automatic logic is_rtype_funct(input logic [5:0] funct);
    return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
           (funct == FN_OR)  || (funct == FN_SLT);
  endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// alu_decoder: combinational ALU control decode.
// Ports:
//   aluop      in  2  operation class: 00 add, 01 sub, 10 use funct
//   funct      in  6  instr[5:0]
//   alucontrol out 3  ALU operation code for the datapath
// Unknown funct values (and the unused aluop 11) fall back to add; illegal
// R-type functions are trapped by the FSM before they reach execute.
module alu_decoder
  import mc_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statements leaves it unassigned and infers a latch.
  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle control unit for the MIPS datapath.
// A Moore FSM sequences fetch/decode/execute/memory/writeback for lw, sw,
// R-type (add/sub/and/or/slt), beq, addi and j. The memory handshake
// (memready) gates the FETCH load enables and the MEMWR retire; zero gates
// the branch PC load; DECODE flags unsupported instructions.
// Ports:
//   clk, reset (async, active-high)
//   op, funct      in   instruction fields from the instruction register
//   zero           in   ALU zero flag
//   memready       in   memory access completes this cycle
//   pcEn, IorD, memwrite, IRwrite, regdst, memtoreg, regwrite,
//   alusrcA, alusrcB, pcsrc, alucontrol   out  datapath controls
//   illegal, retire                         out  one-cycle status pulses
module mc_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       memready,
  output logic       pcEn,
  output logic       IorD,
  output logic       memwrite,
  output logic       IRwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrcA,
  output logic [1:0] alusrcB,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal,
  output logic       retire
);

  state_t     state_q, state_d;
  logic [1:0] aluop;

  // Architectural strobes before reset gating.
  logic pcen_c, memwrite_c, irwrite_c, regwrite_c, illegal_c, retire_c;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    aluop      = ALUOP_ADD;
    pcen_c     = 1'b0;
    memwrite_c = 1'b0;
    irwrite_c  = 1'b0;
    regwrite_c = 1'b0;
    illegal_c  = 1'b0;
    retire_c   = 1'b0;
    IorD       = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrcA    = 1'b0;
    alusrcB    = SRCB_REGB;
    pcsrc      = PCSRC_ALURES;

    case (state_q)
      FETCH: begin
        alusrcB = SRCB_FOUR;
        // Instruction and PC+4 are committed only once memory delivers.
        if (memready) begin
          irwrite_c = 1'b1;
          pcen_c    = 1'b1;
          state_d   = DECODE;
        end
      end

      DECODE: begin
        // Precompute the branch target into aluout.
        alusrcB = SRCB_IMMSH;
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE: begin
            if (is_rtype_funct(funct)) begin
              state_d = RTYPEEX;
            end else begin
              illegal_c = 1'b1;
              state_d   = FETCH;
            end
          end
          OP_BEQ:  state_d = BEQEX;
          OP_ADDI: state_d = ADDIEX;
          OP_J:    state_d = JEX;
          default: begin
            illegal_c = 1'b1;
            state_d   = FETCH;
          end
        endcase
      end

      MEMADR: begin
        alusrcA = 1'b1;
        alusrcB = SRCB_IMM;
        state_d = (op == OP_SW) ? MEMWR : MEMRD;
      end

      MEMRD: begin
        IorD = 1'b1;
        if (memready) state_d = MEMWB;
      end

      MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_c = 1'b1;
        retire_c   = 1'b1;
        state_d    = FETCH;
      end

      MEMWR: begin
        // The write strobe stays up for the whole access; the store retires
        // on the cycle memory accepts it.
        IorD       = 1'b1;
        memwrite_c = 1'b1;
        if (memready) begin
          retire_c = 1'b1;
          state_d  = FETCH;
        end
      end

      RTYPEEX: begin
        alusrcA = 1'b1;
        aluop   = ALUOP_FUNCT;
        state_d = RTYPEWB;
      end

      RTYPEWB: begin
        regdst     = 1'b1;
        regwrite_c = 1'b1;
        retire_c   = 1'b1;
        state_d    = FETCH;
      end

      BEQEX: begin
        alusrcA  = 1'b1;
        aluop    = ALUOP_SUB;
        pcsrc    = PCSRC_ALUOUT;
        pcen_c   = zero;
        retire_c = 1'b1;
        state_d  = FETCH;
      end

      ADDIEX: begin
        alusrcA = 1'b1;
        alusrcB = SRCB_IMM;
        state_d = ADDIWB;
      end

      ADDIWB: begin
        regwrite_c = 1'b1;
        retire_c   = 1'b1;
        state_d    = FETCH;
      end

      JEX: begin
        pcsrc    = PCSRC_JUMP;
        pcen_c   = 1'b1;
        retire_c = 1'b1;
        state_d  = FETCH;
      end

      default: state_d = FETCH;
    endcase
  end

  alu_decoder u_alu_decoder (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

  // While reset is high the state is already FETCH, but FETCH would still
  // raise IRwrite/pcEn on memready; suppress every write enable and pulse.
  assign pcEn     = pcen_c     & ~reset;
  assign memwrite = memwrite_c & ~reset;
  assign IRwrite  = irwrite_c  & ~reset;
  assign regwrite = regwrite_c & ~reset;
  assign illegal  = illegal_c  & ~reset;
  assign retire   = retire_c   & ~reset;

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller. Each instruction is expanded into
// the list of control steps it must produce (one entry per cycle, with
// memory-wait and zero-gating flags); a single compare path checks every
// cycle's outputs against that list while memready, zero and the don't-care
// fetch-time op/funct are randomized.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero, memready;
  logic       pcEn, IorD, memwrite, IRwrite, regdst, memtoreg, regwrite;
  logic       alusrcA;
  logic [1:0] alusrcB, pcsrc;
  logic [2:0] alucontrol;
  logic       illegal, retire;

  mc_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .memready   (memready),
    .pcEn       (pcEn),
    .IorD       (IorD),
    .memwrite   (memwrite),
    .IRwrite    (IRwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .regwrite   (regwrite),
    .alusrcA    (alusrcA),
    .alusrcB    (alusrcB),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol),
    .illegal    (illegal),
    .retire     (retire)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcEn, IorD, memwrite, IRwrite, regdst, memtoreg, regwrite, alusrcA;
    logic [1:0] alusrcB, pcsrc;
    logic [2:0] alucontrol;
    logic       illegal, retire;
  } out_t;

  // mem_wait: step repeats until memready; mem_gate: IRwrite/pcEn/retire
  // only when memready; zero_gate: pcEn only when zero.
  typedef struct packed {
    out_t o;
    logic mem_wait, mem_gate, zero_gate;
  } step_t;

  step_t      steps[$];
  int         idx;
  int         n_cmp = 0, n_bad = 0;
  bit         rand_mr;
  int         fetch_waits, mem_waits, zero_mode;
  logic [5:0] cur_op, cur_funct;
  int         c_memwrite, c_regwrite, c_retire, c_illegal, c_pcen, c_irwrite;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic out_t dut_out();
    out_t v;
    v = '{pcEn, IorD, memwrite, IRwrite, regdst, memtoreg, regwrite, alusrcA,
          alusrcB, pcsrc, alucontrol, illegal, retire};
    return v;
  endfunction

  function automatic out_t quiet();
    out_t v;
    v = '0;
    v.alucontrol = 3'b010;
    return v;
  endfunction

  // While reset: FETCH mux values, every strobe low.
  function automatic out_t reset_vec();
    out_t v;
    v = quiet();
    v.alusrcB = 2'b01;
    return v;
  endfunction

  function automatic step_t mk(input out_t o, input bit w, input bit g, input bit z);
    step_t s;
    s.o = o; s.mem_wait = w; s.mem_gate = g; s.zero_gate = z;
    return s;
  endfunction

  // Expand one instruction into its expected per-cycle control steps.
  task automatic build(input logic [5:0] o_p, input logic [5:0] f_n);
    out_t o;
    bit   legal_rt;
    logic [2:0] rt_alu;
    steps.delete();
    o = reset_vec(); o.IRwrite = 1'b1; o.pcEn = 1'b1;
    steps.push_back(mk(o, 1, 1, 0));                       // fetch
    legal_rt = 1'b1;
    case (f_n)
      6'b100000: rt_alu = 3'b010;
      6'b100010: rt_alu = 3'b110;
      6'b100100: rt_alu = 3'b000;
      6'b100101: rt_alu = 3'b001;
      6'b101010: rt_alu = 3'b111;
      default: begin rt_alu = 3'b010; legal_rt = 1'b0; end
    endcase
    o = quiet(); o.alusrcB = 2'b11;                        // decode
    if (!(o_p inside {6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010} ||
          (o_p == 6'b000000 && legal_rt)))
      o.illegal = 1'b1;
    steps.push_back(mk(o, 0, 0, 0));
    if (o.illegal) return;
    case (o_p)
      6'b100011, 6'b101011: begin
        o = quiet(); o.alusrcA = 1; o.alusrcB = 2'b10;
        steps.push_back(mk(o, 0, 0, 0));
        if (o_p == 6'b100011) begin
          o = quiet(); o.IorD = 1;
          steps.push_back(mk(o, 1, 0, 0));
          o = quiet(); o.memtoreg = 1; o.regwrite = 1; o.retire = 1;
          steps.push_back(mk(o, 0, 0, 0));
        end else begin
          o = quiet(); o.IorD = 1; o.memwrite = 1; o.retire = 1;
          steps.push_back(mk(o, 1, 1, 0));
        end
      end
      6'b000000: begin
        o = quiet(); o.alusrcA = 1; o.alusrcB = 2'b00; o.alucontrol = rt_alu;
        steps.push_back(mk(o, 0, 0, 0));
        o = quiet(); o.regdst = 1; o.regwrite = 1; o.retire = 1;
        steps.push_back(mk(o, 0, 0, 0));
      end
      6'b000100: begin
        o = quiet(); o.alusrcA = 1; o.alucontrol = 3'b110; o.pcsrc = 2'b01;
        o.pcEn = 1; o.retire = 1;
        steps.push_back(mk(o, 0, 0, 1));
      end
      6'b001000: begin
        o = quiet(); o.alusrcA = 1; o.alusrcB = 2'b10;
        steps.push_back(mk(o, 0, 0, 0));
        o = quiet(); o.regwrite = 1; o.retire = 1;
        steps.push_back(mk(o, 0, 0, 0));
      end
      default: begin                                       // j
        o = quiet(); o.pcsrc = 2'b10; o.pcEn = 1; o.retire = 1;
        steps.push_back(mk(o, 0, 0, 0));
      end
    endcase
  endtask

  // One clock: drive inputs, compare mid-cycle, advance on the edge.
  // Entered and left at posedge+1.
  task automatic step_cycle(input string tag);
    step_t s;
    out_t  e;
    logic  mr;
    s = steps[idx];
    if (rand_mr)                                    mr = ($urandom_range(0, 3) != 0);
    else if (s.mem_wait && idx == 0 && fetch_waits > 0) begin mr = 1'b0; fetch_waits--; end
    else if (s.mem_wait && idx > 0 && mem_waits > 0)    begin mr = 1'b0; mem_waits--;   end
    else                                            mr = 1'b1;
    memready = mr;
    zero = (zero_mode == 0) ? 1'($urandom_range(0, 1)) : (zero_mode == 1);
    if (idx == 0) begin
      op    = 6'($urandom_range(0, 63));
      funct = 6'($urandom_range(0, 63));
    end else begin
      op    = cur_op;
      funct = cur_funct;
    end
    #3;
    e = s.o;
    if (s.mem_gate) begin e.IRwrite &= mr; e.pcEn &= mr; e.retire &= mr; end
    if (s.zero_gate) e.pcEn &= zero;
    check($sformatf("%s step%0d", tag, idx), 32'(dut_out()), 32'(e));
    if (memwrite) c_memwrite++;
    if (regwrite) c_regwrite++;
    if (retire)   c_retire++;
    if (illegal)  c_illegal++;
    if (pcEn)     c_pcen++;
    if (IRwrite)  c_irwrite++;
    @(posedge clk); #1;
    if (!s.mem_wait || mr) idx++;
  endtask

  task automatic run_one(input string tag, input logic [5:0] o_p, input logic [5:0] f_n,
                         output int cycles);
    cur_op = o_p; cur_funct = f_n;
    build(o_p, f_n);
    idx = 0; cycles = 0;
    c_memwrite = 0; c_regwrite = 0; c_retire = 0; c_illegal = 0; c_pcen = 0; c_irwrite = 0;
    while (idx < steps.size() && cycles < 200) begin
      step_cycle(tag);
      cycles++;
    end
    check({tag, " timeout"}, 32'(idx < steps.size()), 32'd0);
  endtask

  task automatic directed(input int fw, input int mw, input int zm);
    rand_mr = 1'b0; fetch_waits = fw; mem_waits = mw; zero_mode = zm;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int rw_seen;
    logic [5:0] rt_fns [5];
    rt_fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    // Reset with memready high: FETCH muxes, all strobes suppressed.
    reset = 1'b1; memready = 1'b1; zero = 1'b0; op = 6'b100011; funct = '0;
    #2 check("reset async", 32'(dut_out()), 32'(reset_vec()));
    @(posedge clk); #1;
    check("reset held", 32'(dut_out()), 32'(reset_vec()));
    reset = 1'b0;

    // lw, no waits: 5 cycles, one regwrite, one retire.
    directed(0, 0, 0);
    run_one("lw", 6'b100011, 6'h11, cyc);
    check("lw cycles", 32'(cyc), 32'd5);
    check("lw regwrite count", 32'(c_regwrite), 32'd1);
    check("lw retire count", 32'(c_retire), 32'd1);

    // sw with 3 wait cycles in MEMWR.
    directed(0, 3, 0);
    run_one("sw", 6'b101011, 6'h05, cyc);
    check("sw cycles", 32'(cyc), 32'd7);
    check("sw memwrite count", 32'(c_memwrite), 32'd4);
    check("sw retire count", 32'(c_retire), 32'd1);

    // beq taken / not taken.
    directed(0, 0, 1);
    run_one("beq z1", 6'b000100, 6'h00, cyc);
    check("beq z1 cycles", 32'(cyc), 32'd3);
    check("beq z1 pcEn count", 32'(c_pcen), 32'd2);
    directed(0, 0, 2);
    run_one("beq z0", 6'b000100, 6'h00, cyc);
    check("beq z0 cycles", 32'(cyc), 32'd3);
    check("beq z0 pcEn count", 32'(c_pcen), 32'd1);

    // slt, addi, j.
    directed(0, 0, 0);
    run_one("slt", 6'b000000, 6'b101010, cyc);
    check("slt cycles", 32'(cyc), 32'd4);
    run_one("j", 6'b000010, 6'h2a, cyc);
    check("j cycles", 32'(cyc), 32'd3);

    // Illegal opcode and illegal funct.
    run_one("illegal op", 6'b111111, 6'h00, cyc);
    check("illegal op cycles", 32'(cyc), 32'd2);
    check("illegal op pulses", 32'(c_illegal), 32'd1);
    check("illegal op writes", 32'(c_regwrite + c_memwrite), 32'd0);
    run_one("illegal fn", 6'b000000, 6'b000000, cyc);
    check("illegal fn cycles", 32'(cyc), 32'd2);
    check("illegal fn pulses", 32'(c_illegal), 32'd1);
    check("illegal fn writes", 32'(c_regwrite + c_memwrite), 32'd0);

    // Reset asserted in ADDIEX aborts the addi before its writeback.
    directed(0, 0, 0);
    cur_op = 6'b001000; cur_funct = 6'h00;
    build(cur_op, cur_funct);
    idx = 0;
    step_cycle("addi pre-rst");
    step_cycle("addi pre-rst");
    memready = 1'b1; op = cur_op; funct = cur_funct;
    #2 check("addiex", 32'(dut_out()), 32'(steps[2].o));
    reset = 1'b1;
    #1 check("rst in addiex", 32'(dut_out()), 32'(reset_vec()));
    rw_seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (regwrite) rw_seen++;
      check("rst hold", 32'(dut_out()), 32'(reset_vec()));
    end
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst regwrite seen", 32'(rw_seen), 32'd0);

    // Fetch stalled 2 cycles, then addi completes normally.
    directed(2, 0, 0);
    run_one("addi fetch wait", 6'b001000, 6'h00, cyc);
    check("addi fetch wait cycles", 32'(cyc), 32'd6);
    check("addi IRwrite count", 32'(c_irwrite), 32'd1);

    // Randomized instruction stream.
    rand_mr = 1'b1; zero_mode = 0;
    for (int n = 0; n < 300; n++) begin
      logic [5:0] o_p, f_n;
      f_n = 6'($urandom_range(0, 63));
      case ($urandom_range(0, 9))
        0, 9: o_p = 6'b100011;
        1: o_p = 6'b101011;
        2: begin o_p = 6'b000000; f_n = rt_fns[$urandom_range(0, 4)]; end
        3: o_p = 6'b000100;
        4: o_p = 6'b001000;
        5: o_p = 6'b000010;
        6: o_p = 6'b111111;
        7: o_p = 6'b000000;
        default: o_p = 6'($urandom_range(0, 63));
      endcase
      run_one("rand", o_p, f_n, cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
